chargen_fifo: RTL and testbench

//  RFC 864-style character generator feeding an on-chip FIFO, which a

---
 rtl/chargen_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/chargen_fifo.sv | 108 ++++++++++
 tb/tb_chargen_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/chargen_pkg.sv
// Shared constants, FSM state type and character wrap helper for the
// character generator.
package chargen_pkg;

    localparam logic [7:0] ASCII_FIRST = 8'h20;
    localparam logic [7:0] ASCII_LAST  = 8'h7E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [1:0] {
        IDLE,
        CHAR,
        CR,
        LF
    } chargen_state_t;

    function automatic logic [7:0] next_char(input logic [7:0] c);
        return (c == ASCII_LAST) ? ASCII_FIRST : c + 8'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO on a register array; the head entry is read
// combinationally so a push into an empty FIFO is visible after one edge.
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          ready,
    output logic [DW-1:0] rd_data,
    output logic          valid,
    output logic          full,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    // Full comes from the registered count, so a pop in the same cycle
    // never frees a slot for the push.
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign valid   = (count_reg != '0);
    assign do_push = push && !full;
    assign do_pop  = valid && ready;
    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/chargen_fifo.sv
// RFC 864-style character generator writing rotating printable-ASCII lines
// terminated by CR LF into a FWFT FIFO drained over valid/ready.
module chargen_fifo
    import chargen_pkg::*;
#(
    parameter int LINE_LEN = 72,
    parameter int AW       = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        en,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [AW:0] fifo_level,
    output logic        line_strobe
);

    chargen_state_t state_reg, state_next;
    logic [7:0]     cur_char_reg, cur_char_next;
    logic [7:0]     line_start_reg, line_start_next;
    logic [7:0]     col_reg, col_next;
    logic           push;
    logic [7:0]     push_data;
    logic           full;
    logic           can_push;

    // Disabled or full both simply hold every register, so nothing is
    // skipped or repeated when generation resumes.
    assign can_push = en && !full;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg      <= IDLE;
            cur_char_reg   <= ASCII_FIRST;
            line_start_reg <= ASCII_FIRST;
            col_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            cur_char_reg   <= cur_char_next;
            line_start_reg <= line_start_next;
            col_reg        <= col_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cur_char_next   = cur_char_reg;
        line_start_next = line_start_reg;
        col_next        = col_reg;
        push            = 1'b0;
        push_data       = cur_char_reg;
        line_strobe     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next    = CHAR;
                    cur_char_next = line_start_reg;
                end
            end
            CHAR: begin
                if (can_push) begin
                    push          = 1'b1;
                    cur_char_next = next_char(cur_char_reg);
                    col_next      = col_reg + 8'd1;
                    if (col_reg == 8'(LINE_LEN - 1)) begin
                        state_next = CR;
                    end
                end
            end
            CR: begin
                push_data = ASCII_CR;
                if (can_push) begin
                    push       = 1'b1;
                    state_next = LF;
                end
            end
            LF: begin
                push_data = ASCII_LF;
                if (can_push) begin
                    push            = 1'b1;
                    line_strobe     = 1'b1;
                    line_start_next = next_char(line_start_reg);
                    cur_char_next   = next_char(line_start_reg);
                    col_next        = '0;
                    state_next      = CHAR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    sync_fifo #(
        .DW(8),
        .AW(AW)
    ) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (push),
        .push_data (push_data),
        .ready     (tx_ready),
        .rd_data   (tx_data),
        .valid     (tx_valid),
        .full      (full),
        .count     (fifo_level)
    );

endmodule

// File: tb/tb_chargen_fifo.sv
// Self-checking bench for chargen_fifo: every popped byte is compared with
// the byte-index formula of the character stream, plus directed literals.
module tb_chargen_fifo;

    localparam int L  = 4;
    localparam int AW = 4;

    logic        clk;
    logic        n_rst;
    logic        en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [AW:0] fifo_level;
    logic        line_strobe;

    int checks = 0;
    int errors = 0;
    int pop_cnt = 0;
    int strobe_cnt = 0;
    logic [7:0] pop_log [0:2047];

    chargen_fifo #(.LINE_LEN(L), .AW(AW)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .en          (en),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .fifo_level  (fifo_level),
        .line_strobe (line_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte k of the stream: line n holds chars starting at 0x20+n (mod 95).
    function automatic logic [7:0] exp_byte(input int k);
        int ln;
        int pos;
        ln  = k / (L + 2);
        pos = k % (L + 2);
        if (pos < L)       return 8'(32 + (ln + pos) % 95);
        else if (pos == L) return 8'h0D;
        else               return 8'h0A;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Compare process: one pass per cycle, away from the rising edge.
    initial begin
        logic       prev_valid;
        logic       prev_ready;
        logic [7:0] prev_data;
        logic       have_prev;
        have_prev = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                pop_cnt    = 0;
                strobe_cnt = 0;
                have_prev  = 1'b0;
            end else begin
                check("valid_vs_level", int'(tx_valid), int'(fifo_level != 0));
                check("level_bound", int'(fifo_level <= 16), 1);
                check("strobe_count", strobe_cnt, (pop_cnt + int'(fifo_level)) / (L + 2));
                if (have_prev && prev_valid && !prev_ready) begin
                    check("hold_valid", int'(tx_valid), 1);
                    check("hold_data", int'(tx_data), int'(prev_data));
                end
                if (tx_valid && tx_ready) begin
                    check("stream_byte", int'(tx_data), int'(exp_byte(pop_cnt)));
                    $display("pop %0d: data=0x%02h level=%0d", pop_cnt, tx_data, fifo_level);
                    if (pop_cnt < 2048) pop_log[pop_cnt] = tx_data;
                    pop_cnt++;
                end
                if (line_strobe) strobe_cnt++;
                prev_valid = tx_valid;
                prev_ready = tx_ready;
                prev_data  = tx_data;
                have_prev  = 1'b1;
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_pops(input int n, input int budget);
        int c;
        c = 0;
        while (pop_cnt < n && c < budget) begin
            step(1);
            c++;
        end
        check("wait_pops_timeout", int'(pop_cnt >= n), 1);
    endtask

    task automatic wait_level(input int lvl, input int budget);
        int c;
        c = 0;
        while (int'(fifo_level) != lvl && c < budget) begin
            step(1);
            c++;
        end
        check("wait_level_timeout", int'(fifo_level), lvl);
    endtask

    initial begin
        logic [7:0] tbl2 [12];
        logic [7:0] tbl4 [12];
        tbl2 = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h0D, 8'h0A,
                 8'h21, 8'h22, 8'h23, 8'h24, 8'h0D, 8'h0A};
        tbl4 = '{8'h7E, 8'h20, 8'h21, 8'h22, 8'h0D, 8'h0A,
                 8'h20, 8'h21, 8'h22, 8'h23, 8'h0D, 8'h0A};

        // Reset held with the generator enabled and the consumer ready.
        n_rst = 1'b1;
        en = 1'b1;
        tx_ready = 1'b1;
        #1 n_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("rst_data", int'(tx_data), 0);
            check("rst_valid", int'(tx_valid), 0);
            check("rst_level", int'(fifo_level), 0);
            check("rst_strobe", int'(line_strobe), 0);
        end

        // First-byte latency from en with an empty FIFO.
        en = 1'b0;
        tx_ready = 1'b0;
        step(1);
        n_rst = 1'b1;
        step(2);
        en = 1'b1;
        @(posedge clk);
        #1 check("lat_valid_e", int'(tx_valid), 0);
        @(posedge clk);
        #1 check("lat_valid_e1", int'(tx_valid), 1);
        check("lat_data", int'(tx_data), 8'h20);

        // Back-pressure: FIFO fills to its depth and the head stays put.
        step(30);
        check("full_level", int'(fifo_level), 16);
        check("full_head", int'(tx_data), 8'h20);
        step(5);
        check("full_level_hold", int'(fifo_level), 16);

        // Release the consumer; first twelve bytes of the stream.
        tx_ready = 1'b1;
        wait_pops(12, 100);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("line_seq[%0d]", i), int'(pop_log[i]), int'(tbl2[i]));
        end

        // Drain, refill to 9 entries, then reset mid-operation.
        en = 1'b0;
        wait_level(0, 40);
        en = 1'b1;
        tx_ready = 1'b0;
        wait_level(9, 40);
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1 check("midrst_valid", int'(tx_valid), 0);
        check("midrst_level", int'(fifo_level), 0);
        step(2);
        tx_ready = 1'b1;
        n_rst = 1'b1;
        wait_pops(1, 20);
        check("post_rst_first", int'(pop_log[0]), 8'h20);

        // Freeze mid-line for 10 cycles; FIFO empties, stream resumes.
        wait_pops(14, 50);
        en = 1'b0;
        step(10);
        check("frozen_level", int'(fifo_level), 0);
        check("frozen_valid", int'(tx_valid), 0);
        en = 1'b1;

        // Run until the line starting at 0x7E and the wrap after it.
        wait_pops(576, 3000);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("wrap_seq[%0d]", i), int'(pop_log[564 + i]), int'(tbl4[i]));
        end

        en = 1'b0;
        wait_level(0, 40);
        step(2);
        check("final_strobes", strobe_cnt, pop_cnt / (L + 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
